obi_rr_arbiter: RTL

- Shares one OBI subordinate (the zeroHETI testbench SRAM) between NumMgr OBI managers, e.g. the Ibex instruction and data ports.
- Round-robin request arbitration.
- Tracks outstanding transactions in an in-order ID FIFO so each response returns to the manager that issued it.
- Sits between the core buses and the SRAM; replaces the generic mux in bench tops.

---
 rtl/zeroheti_pkg.sv | 26 ++
 rtl/obi_id_fifo.sv | 72 +++++++
 rtl/obi_rr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/zeroheti_pkg.sv
// -----------------------------------------------------------------------------
// zeroheti_pkg
//   Shared types and helpers for the zeroHETI bench infrastructure.
//   - obi_arb_cfg_t      : configuration record for the OBI round-robin arbiter
//   - ObiArbCfgDefault   : default arbiter configuration (2 managers, 2 in flight)
//   - id_width()         : width of an index into n entries (at least 1 bit)
//   - IdWidth            : manager-ID width for the default configuration
// -----------------------------------------------------------------------------
package zeroheti_pkg;

    typedef struct packed {
        int unsigned num_mgr;
        int unsigned max_trans;
    } obi_arb_cfg_t;

    localparam obi_arb_cfg_t ObiArbCfgDefault = '{num_mgr: 2, max_trans: 2};

    // A single-entry index still needs one bit to form a legal vector.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IdWidth = (ObiArbCfgDefault.num_mgr > 1)
                                    ? $clog2(ObiArbCfgDefault.num_mgr) : 1;

endpackage

// File: rtl/obi_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_id_fifo
//   In-order FIFO of manager IDs for granted-but-unanswered OBI transactions.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     push_i/data_i  write one entry (ignored when full and not popping)
//     pop_i          drop the head entry (ignored when empty)
//     data_o         head entry
//     empty_o        no entries held
//     count_o        number of entries held (0..Depth)
// -----------------------------------------------------------------------------
module obi_id_fifo
    import zeroheti_pkg::*;
#(
    parameter int unsigned Depth    = 2,
    parameter int unsigned Width    = 1,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned PtrWidth = id_width(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] count;
    logic                full, do_push, do_pop;

    assign full    = (count == CntWidth'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count/pointers alone decide which
    // entries are valid, so resetting the payload would only cost flops.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter
//   Shares one OBI subordinate between NumMgr OBI managers. Requests are
//   arbitrated round-robin with zero added latency; a request stalled by the
//   subordinate is locked so its fields stay stable. An in-order ID FIFO
//   (obi_id_fifo) returns each response to the manager that issued it.
//
//   Build option:
//     OBI_ARB_FIXED_PRIO_EN  lowest-index requester always wins; no rr pointer.
//
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     mgr_req_i/we_i      per-manager request / write enable
//     mgr_be_i/addr_i/wdata_i  packed per-manager fields, manager 0 in LSBs
//     mgr_gnt_o           one-hot grant
//     mgr_rvalid_o        one-hot response valid
//     mgr_rdata_o/err_o   response data / error, broadcast
//     sbr_req_o, sbr_we_o, sbr_be_o, sbr_addr_o, sbr_wdata_o  to subordinate
//     sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i         from subordinate
//     unexp_rsp_o         sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module obi_rr_arbiter
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgr    = ObiArbCfgDefault.num_mgr,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = ObiArbCfgDefault.max_trans
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumMgr-1:0]               mgr_req_i,
    input  logic [NumMgr-1:0]               mgr_we_i,
    input  logic [NumMgr*(DataWidth/8)-1:0] mgr_be_i,
    input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
    input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
    output logic [NumMgr-1:0]               mgr_gnt_o,
    output logic [NumMgr-1:0]               mgr_rvalid_o,
    output logic [DataWidth-1:0]            mgr_rdata_o,
    output logic                            mgr_err_o,
    output logic                            sbr_req_o,
    output logic                            sbr_we_o,
    output logic [DataWidth/8-1:0]          sbr_be_o,
    output logic [AddrWidth-1:0]            sbr_addr_o,
    output logic [DataWidth-1:0]            sbr_wdata_o,
    input  logic                            sbr_gnt_i,
    input  logic                            sbr_rvalid_i,
    input  logic [DataWidth-1:0]            sbr_rdata_i,
    input  logic                            sbr_err_i,
    output logic                            unexp_rsp_o
);

    localparam int unsigned IdW  = id_width(NumMgr);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned BeW  = DataWidth / 8;

    // Unpacked views of the packed manager buses.
    logic [BeW-1:0]       be_arr    [NumMgr];
    logic [AddrWidth-1:0] addr_arr  [NumMgr];
    logic [DataWidth-1:0] wdata_arr [NumMgr];

    for (genvar g = 0; g < NumMgr; g++) begin : g_unpack
        assign be_arr[g]    = mgr_be_i[g*BeW +: BeW];
        assign addr_arr[g]  = mgr_addr_i[g*AddrWidth +: AddrWidth];
        assign wdata_arr[g] = mgr_wdata_i[g*DataWidth +: DataWidth];
    end

    logic [IdW-1:0]  sel, locked_idx, head;
    logic            lock_q, any_req, full, handshake, id_empty;
    logic [CntW-1:0] id_count;

    assign any_req   = |mgr_req_i;
    assign full      = (id_count == CntW'(MaxTrans));
    assign sbr_req_o = any_req & ~full;
    assign handshake = sbr_req_o & sbr_gnt_i;

`ifdef OBI_ARB_FIXED_PRIO_EN
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NumMgr; i++) begin
            if (!found && mgr_req_i[i]) begin
                sel   = IdW'(i);
                found = 1'b1;
            end
        end
        if (lock_q) sel = locked_idx;
    end
`else
    logic [IdW-1:0] rr_ptr;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic        found;
        int unsigned cand;
        sel   = '0;
        found = 1'b0;
        cand  = 0;
        // Scan starting at the pointer; wrap by a single subtraction.
        for (int unsigned k = 0; k < NumMgr; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NumMgr) cand = cand - NumMgr;
            if (!found && mgr_req_i[IdW'(cand)]) begin
                sel   = IdW'(cand);
                found = 1'b1;
            end
        end
        if (lock_q) sel = locked_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (sel == IdW'(NumMgr - 1)) ? '0 : sel + IdW'(1);
        end
    end
`endif

    // Fields read as zero when nobody is asking.
    assign sbr_we_o    = any_req ? mgr_we_i[sel]  : 1'b0;
    assign sbr_be_o    = any_req ? be_arr[sel]    : '0;
    assign sbr_addr_o  = any_req ? addr_arr[sel]  : '0;
    assign sbr_wdata_o = any_req ? wdata_arr[sel] : '0;

    always_comb begin
        mgr_gnt_o = '0;
        if (handshake) mgr_gnt_o[sel] = 1'b1;
    end

    always_comb begin
        mgr_rvalid_o = '0;
        if (sbr_rvalid_i && !id_empty) mgr_rvalid_o[head] = 1'b1;
    end

    assign mgr_rdata_o = sbr_rdata_i;
    assign mgr_err_o   = sbr_err_i;

    // A stalled request pins the selection until the subordinate takes it.
    // sbr_req_o is already low when full, so no lock forms in that state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            locked_idx  <= '0;
            unexp_rsp_o <= 1'b0;
        end else begin
            if (handshake) begin
                lock_q <= 1'b0;
            end else if (sbr_req_o) begin
                lock_q     <= 1'b1;
                locked_idx <= sel;
            end
            if (sbr_rvalid_i && id_empty) unexp_rsp_o <= 1'b1;
        end
    end

    // The subordinate answers no earlier than the cycle after a grant, so a
    // same-cycle pop always removes the older head, never the entry pushed now.
    obi_id_fifo #(
        .Depth    (MaxTrans),
        .Width    (IdW),
        .CntWidth (CntW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (sbr_rvalid_i),
        .data_o  (head),
        .empty_o (id_empty),
        .count_o (id_count)
    );

endmodule
